// File: rtl/pdm_mic_receiver.sv
// PDM microphone front end: generates micClk, samples micData on each falling
// micClk edge and reports the count of ones per DECIM-bit window through a valid/ready hold register.
module pdm_mic_receiver #(
    parameter int MIC_HALF = 50,
    parameter int DECIM    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        micData,
    output logic        micClk,
    output logic        micLRSel,
    output logic [15:0] sample,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam int HALF_W = $clog2(MIC_HALF);
    localparam int BIT_W  = $clog2(DECIM);
    // One extra state so a window of all ones (DECIM) fits without wrapping.
    localparam int ACC_W  = $clog2(DECIM + 1);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(MIC_HALF - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DECIM - 1);

    logic              sync1_reg;
    logic              sync2_reg;
    logic [HALF_W-1:0] half_cnt_reg;
    logic              mic_clk_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [ACC_W-1:0]  ones_acc_reg;
    logic [15:0]       sample_reg;
    logic              sample_valid_reg;
    logic              overrun_reg;

    logic              half_wrap;
    logic              fall_tick;
    logic              window_done;
    logic [ACC_W-1:0]  window_total;
    logic              transfer;
    logic              load_sample;
    logic              overrun_evt;

    always_comb begin
        half_wrap    = en && (half_cnt_reg == HALF_LAST);
        fall_tick    = half_wrap && mic_clk_reg;
        window_done  = fall_tick && (bit_cnt_reg == BIT_LAST);
        window_total = ones_acc_reg + ACC_W'(sync2_reg);
        transfer     = sample_valid_reg && sample_ready;
        // A transfer on the completion cycle frees the holding register in time.
        load_sample  = window_done && (!sample_valid_reg || sample_ready);
        overrun_evt  = window_done && sample_valid_reg && !sample_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= micData;
            sync2_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt_reg <= '0;
            mic_clk_reg  <= 1'b0;
            bit_cnt_reg  <= '0;
            ones_acc_reg <= '0;
        end else if (!en) begin
            half_cnt_reg <= '0;
            mic_clk_reg  <= 1'b0;
            bit_cnt_reg  <= '0;
            ones_acc_reg <= '0;
        end else begin
            if (half_wrap) begin
                half_cnt_reg <= '0;
                mic_clk_reg  <= ~mic_clk_reg;
            end else begin
                half_cnt_reg <= half_cnt_reg + 1'b1;
            end
            if (fall_tick) begin
                if (window_done) begin
                    bit_cnt_reg  <= '0;
                    ones_acc_reg <= '0;
                end else begin
                    bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                    ones_acc_reg <= window_total;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            if (load_sample) begin
                sample_reg       <= 16'(window_total);
                sample_valid_reg <= 1'b1;
            end else if (transfer) begin
                sample_valid_reg <= 1'b0;
            end
            if (overrun_evt)
                overrun_reg <= 1'b1;
            else if (overrun_clr)
                overrun_reg <= 1'b0;
        end
    end

    assign micClk       = mic_clk_reg;
    assign micLRSel     = 1'b0;
    assign sample       = sample_reg;
    assign sample_valid = sample_valid_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_pdm_mic_receiver.sv
// Directed bench for pdm_mic_receiver: divider timing, window counts, handshake,
// overrun, enable and asynchronous reset behaviour.
module tb_pdm_mic_receiver;

    localparam int MIC_HALF = 4;
    localparam int DECIM    = 64;
    localparam int WIN      = 2 * MIC_HALF * DECIM;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        micData;
    logic        micClk;
    logic        micLRSel;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        overrun_clr;

    int tests_run    = 0;
    int tests_failed = 0;
    int data_mode    = 1;  // 0: constant 0, 1: constant 1, 2: toggle each bit

    pdm_mic_receiver #(.MIC_HALF(MIC_HALF), .DECIM(DECIM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .micData      (micData),
        .micClk       (micClk),
        .micLRSel     (micLRSel),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // New data is presented on micClk rise, well ahead of the capturing fall.
    initial begin
        forever begin
            @(posedge micClk);
            case (data_mode)
                0:       micData = 1'b0;
                1:       micData = 1'b1;
                default: micData = ~micData;
            endcase
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    // Counts rising edges until sample_valid is seen; bounded by 2 windows.
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sample_valid && n < 2 * WIN);
        if (!sample_valid)
            check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n;
        int bad;
        rst_n        = 1'b0;
        en           = 1'b1;
        micData      = 1'b1;
        sample_ready = 1'b1;
        overrun_clr  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_micClk", int'(micClk), 0);
        check("rst_micLRSel", int'(micLRSel), 0);
        check("rst_sample", int'(sample), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_overrun", int'(overrun), 0);

        // First micClk rise MIC_HALF cycles after the first enabled cycle.
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!micClk && n < 1000);
        check("first_rise", n, MIC_HALF);

        n = 0;
        do begin @(posedge clk); #1; n++; end while (micClk && n < 1000);
        do begin @(posedge clk); #1; n++; end while (!micClk && n < 1000);
        check("micClk_period", n, 2 * MIC_HALF);

        // Constant ones: full count, one sample per window.
        wait_valid("ones1", n);
        check("ones_sample1", int'(sample), DECIM);
        wait_valid("ones2", n);
        check("ones_interval", n, WIN);
        check("ones_sample2", int'(sample), DECIM);

        data_mode = 0;
        wait_valid("zeros", n);
        check("zeros_sample", int'(sample), 0);

        data_mode = 2;
        wait_valid("toggle", n);
        check("toggle_sample", int'(sample), DECIM / 2);

        // Hold the toggle sample across a second completion -> overrun.
        sample_ready = 1'b0;
        data_mode    = 0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!overrun && n < 2 * WIN);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_sample_kept", int'(sample), DECIM / 2);
        check("ovr_valid_kept", int'(sample_valid), 1);
        repeat (5) @(posedge clk);
        #1;
        check("ovr_sticky", int'(overrun), 1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_cleared", int'(overrun), 0);
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        sample_ready = 1'b0;
        check("xfer_valid_low", int'(sample_valid), 0);

        // Transfer coinciding with window completion keeps valid high.
        wait_valid("held0", n);
        check("held0_sample", int'(sample), 0);
        data_mode = 1;
        repeat (WIN - 1) @(posedge clk);
        @(negedge clk);
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        check("same_cyc_valid", int'(sample_valid), 1);
        check("same_cyc_sample", int'(sample), DECIM);
        check("same_cyc_overrun", int'(overrun), 0);

        // Disable 30 bits into a window; the partial window must vanish.
        repeat (30 * 2 * MIC_HALF + 2) @(posedge clk);
        @(negedge clk);
        en  = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (micClk) bad++;
        end
        check("dis_micClk_high_cycles", bad, 0);
        check("dis_no_sample", int'(sample_valid), 0);
        @(negedge clk);
        en = 1'b1;
        wait_valid("reen", n);
        check("reen_latency", n, WIN);
        check("reen_sample", int'(sample), DECIM);

        // Asynchronous reset mid-window while a sample is held.
        sample_ready = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        check("pre_rst_valid", int'(sample_valid), 1);
        rst_n = 1'b0;
        #1;
        check("arst_sample", int'(sample), 0);
        check("arst_valid", int'(sample_valid), 0);
        check("arst_micClk", int'(micClk), 0);
        check("arst_overrun", int'(overrun), 0);
        sample_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("post_rst", n);
        check("post_rst_latency", n, WIN);
        check("post_rst_sample", int'(sample), DECIM);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
